// File: rtl/apb_slave_regbank_if.sv
// rtl/apb_slave_regbank_if.sv - APB4 bus bundle between the APB master and one register-bank completer
// Ports: none; carries PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB plus the check bits
//        PADDRCHK/PWDATACHK/PSTRBCHK from the master, and PRDATA/PREADY/PSLVERR/PRDATACHK
//        back from the completer.
// Modports: master drives the request side, slave drives the response side.
interface apb_slave_regbank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [ADDR_WIDTH/8-1:0] PADDRCHK;
  logic [DATA_WIDTH/8-1:0] PWDATACHK;
  logic                    PSTRBCHK;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH/8-1:0] PRDATACHK;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PADDRCHK, PWDATACHK, PSTRBCHK,
    input  PRDATA, PREADY, PSLVERR, PRDATACHK
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PADDRCHK, PWDATACHK, PSTRBCHK,
    output PRDATA, PREADY, PSLVERR, PRDATACHK
  );
endinterface

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB4 completer serving NUM_REGS R/W registers with wait states, strobes and parity
// Ports:
//   PCLK     in   APB clock
//   PRESETn  in   async active-low reset
//   apb      slave side of the APB bus (request + check bits in, response + PRDATACHK out)
//   regs_q   out  flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   par_err  out  completion-cycle pulse {strb,wdata,addr} parity mismatch
module apb_slave_regbank #(
  parameter int                  ADDR_WIDTH   = 32,
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  NUM_REGS     = 8,
  parameter int                  OFFSET_WIDTH = 12,
  parameter int                  WAIT_STATES  = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK      = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  apb_slave_regbank_if.slave           apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [2:0]                   par_err
);
  localparam int          NB         = DATA_WIDTH / 8;
  localparam int          AB         = ADDR_WIDTH / 8;
  localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  WS         = 4'(WAIT_STATES);
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                setup_ph, access_ph, no_setup, done_ok, complete;
  logic [IDX_W-1:0]    idx;
  logic [31:0]         word_off;
  logic                addr_err, a_bad, w_bad, s_bad, ro_hit, slverr_c, commit;
  logic [AB-1:0]       addr_par;
  logic [NB-1:0]       wdata_par, rdata_par;
  logic [DATA_WIDTH-1:0] rdata_c;

  assign setup_ph  = apb.PSEL & ~apb.PENABLE;
  assign access_ph = apb.PSEL & apb.PENABLE;
  // An access phase that arrives without a preceding setup completes at once with an error.
  assign no_setup  = access_ph & (state == IDLE);
  assign done_ok   = access_ph & (state == ACCESS) & (cnt == 4'd0);
  // Gated by reset so the bus sees a quiet completer while PRESETn is held low.
  assign complete  = PRESETn & (no_setup | done_ok);

  assign idx      = apb.PADDR[2 +: IDX_W];
  assign word_off = 32'(apb.PADDR[OFFSET_WIDTH-1:2]);
  assign addr_err = (|apb.PADDR[1:0]) | (word_off >= NUM_REGS_U);

  always_comb begin
    addr_par  = '0;
    wdata_par = '0;
    for (int b = 0; b < AB; b++) addr_par[b]  = ^apb.PADDR[8*b +: 8];
    for (int b = 0; b < NB; b++) wdata_par[b] = ^apb.PWDATA[8*b +: 8];
  end

  assign a_bad    = (addr_par != apb.PADDRCHK);
  assign w_bad    = apb.PWRITE & (wdata_par != apb.PWDATACHK);
  assign s_bad    = apb.PWRITE & ((^apb.PSTRB) != apb.PSTRBCHK);
  assign ro_hit   = apb.PWRITE & ~addr_err & RO_MASK[idx];
  assign slverr_c = no_setup | addr_err | a_bad | w_bad | s_bad | ro_hit;
  assign commit   = complete & apb.PWRITE & ~slverr_c;

  always_comb begin
    rdata_c = '0;
    if (complete && !apb.PWRITE && !slverr_c) rdata_c = regs[idx];
  end

  always_comb begin
    rdata_par = '0;
    for (int b = 0; b < NB; b++) rdata_par[b] = ^rdata_c[8*b +: 8];
  end

  assign apb.PREADY    = complete;
  assign apb.PSLVERR   = complete & slverr_c;
  assign apb.PRDATA    = rdata_c;
  assign apb.PRDATACHK = rdata_par;
  assign par_err       = complete ? {s_bad, w_bad, a_bad} : 3'b000;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup_ph) begin
            state <= ACCESS;
            cnt   <= WS;
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            // Master abandoned the transfer: drop it without committing.
            state <= IDLE;
          end else if (!apb.PENABLE) begin
            // Fresh setup while still in ACCESS restarts the wait count.
            cnt <= WS;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-edge commit: a reset mid-transfer can never leave a partially written register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NB; b++)
        if (apb.PSTRB[b]) regs[idx][8*b +: 8] <= apb.PWDATA[8*b +: 8];
    end
  end

  always_comb begin
    regs_q = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - self-checking bench for apb_slave_regbank
module tb_apb_slave_regbank;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        psel, penable, pwrite, pstrbchk;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb, paddrchk, pwdatachk;
  int          sel;

  logic        rdy_a [3];
  logic        err_a [3];
  logic [31:0] prd_a [3];
  logic [3:0]  chk_a [3];
  logic [2:0]  perr_a [3];
  logic [255:0] rq [3];

  // dut 0: no wait states, reg7 read-only; dut 1: 3 wait states; dut 2: 2 wait states
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int         WSK = (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    localparam logic [7:0] ROK = (k == 0) ? 8'h80 : 8'h00;
    apb_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.PSEL      = psel && (sel == k);
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PADDR     = paddr;
    assign bus.PWDATA    = pwdata;
    assign bus.PSTRB     = pstrb;
    assign bus.PADDRCHK  = paddrchk;
    assign bus.PWDATACHK = pwdatachk;
    assign bus.PSTRBCHK  = pstrbchk;
    assign rdy_a[k] = bus.PREADY;
    assign err_a[k] = bus.PSLVERR;
    assign prd_a[k] = bus.PRDATA;
    assign chk_a[k] = bus.PRDATACHK;
    apb_slave_regbank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .OFFSET_WIDTH(12),
                        .WAIT_STATES(WSK), .RO_MASK(ROK)) dut (
      .PCLK(clk), .PRESETn(rst_n), .apb(bus.slave), .regs_q(rq[k]), .par_err(perr_a[k]));
  end

  logic        o_pready, o_pslverr;
  logic [31:0] o_prdata;
  logic [3:0]  o_prdatachk;
  logic [2:0]  o_perr;
  always_comb begin
    o_pready    = rdy_a[sel];
    o_pslverr   = err_a[sel];
    o_prdata    = prd_a[sel];
    o_prdatachk = chk_a[sel];
    o_perr      = perr_a[sel];
  end

  int total = 0;
  int bad = 0;
  logic [31:0] mem [8];
  localparam logic [7:0] RO0 = 8'h80;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    logic [2:0]  fl;
    logic        e;
    logic [31:0] r;
    logic [2:0]  p;
  } vec_t;
  vec_t tbl [20];

  function automatic vec_t mkv(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] st, input logic [2:0] fl, input logic e,
                               input logic [31:0] r, input logic [2:0] p);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.st = st; v.fl = fl; v.e = e; v.r = r; v.p = p;
    return v;
  endfunction

  function automatic logic [3:0] bpar(input logic [31:0] x);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = ^x[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model of dut 0: address arithmetic on the byte offset, a plain word array.
  task automatic model_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, input logic [2:0] fl,
                            output logic e, output logic [31:0] r, output logic [2:0] p);
    int off, i;
    logic [2:0] eff;
    off = int'(a % 32'd4096);
    i   = off / 4;
    eff = w ? fl : {2'b00, fl[0]};
    e   = (off % 4 != 0) || (i >= 8) || (eff != 3'b000);
    if (!e && w && RO0[i]) e = 1'b1;
    p = eff;
    r = 32'h0;
    if (!e && !w) r = mem[i];
    if (!e && w)
      for (int b = 0; b < 4; b++) if (st[b]) mem[i][8*b +: 8] = d[8*b +: 8];
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge, bus released,
  // so consecutive calls form back-to-back transfers.
  task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, input logic [2:0] fl,
                      output logic [31:0] rd, output logic er, output logic [3:0] rc,
                      output logic [2:0] pe, output int waits);
    logic ok;
    sel       = s;
    psel      = 1'b1;
    penable   = 1'b0;
    pwrite    = w;
    paddr     = a;
    pwdata    = w ? d : 32'h0;
    pstrb     = w ? st : 4'h0;
    paddrchk  = bpar(a) ^ {3'b000, fl[0]};
    pwdatachk = (w ? bpar(d) : 4'h0) ^ {3'b000, fl[1]};
    pstrbchk  = (^pstrb) ^ fl[2];
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    ok = 1'b0;
    rd = 32'h0; er = 1'b0; rc = 4'h0; pe = 3'b000;
    repeat (40) begin
      @(negedge clk);
      if (o_pready) begin
        rd = o_prdata; er = o_pslverr; rc = o_prdatachk; pe = o_perr;
        ok = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 1'b0;
    penable = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout actual=no_pready required=pready addr=%h", a);
    end
  endtask

  logic [31:0] rd, er_r;
  logic        er, ee;
  logic [3:0]  rc;
  logic [2:0]  pe, ep;
  logic [31:0] er32;
  int          waits;

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    paddrchk = 0; pwdatachk = 0; pstrbchk = 0; sel = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_pready", {31'b0, rdy_a[k]}, 32'h0);
      chk("rst_prdata", prd_a[k], 32'h0);
      chk("rst_par_err", {29'b0, perr_a[k]}, 32'h0);
      chk("rst_regs_q", {31'b0, |rq[k]}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0]  = mkv(1'b1, 32'h004, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[1]  = mkv(1'b0, 32'h004, 32'h0,        4'h0, 3'b000, 1'b0, 32'hDEADBEEF, 3'b000);
    tbl[2]  = mkv(1'b1, 32'h008, 32'h11223344, 4'hF, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[3]  = mkv(1'b1, 32'h008, 32'hAABBCCDD, 4'h5, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[4]  = mkv(1'b0, 32'h008, 32'h0,        4'h0, 3'b000, 1'b0, 32'h11BB33DD, 3'b000);
    tbl[5]  = mkv(1'b1, 32'h020, 32'h12345678, 4'hF, 3'b000, 1'b1, 32'h0, 3'b000);
    tbl[6]  = mkv(1'b0, 32'h020, 32'h0,        4'h0, 3'b000, 1'b1, 32'h0, 3'b000);
    tbl[7]  = mkv(1'b1, 32'h006, 32'hCAFEF00D, 4'hF, 3'b000, 1'b1, 32'h0, 3'b000);
    tbl[8]  = mkv(1'b0, 32'h004, 32'h0,        4'h0, 3'b000, 1'b0, 32'hDEADBEEF, 3'b000);
    tbl[9]  = mkv(1'b1, 32'h01C, 32'h55555555, 4'hF, 3'b000, 1'b1, 32'h0, 3'b000);
    tbl[10] = mkv(1'b0, 32'h01C, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[11] = mkv(1'b1, 32'h000, 32'h000000FF, 4'hF, 3'b010, 1'b1, 32'h0, 3'b010);
    tbl[12] = mkv(1'b0, 32'h000, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[13] = mkv(1'b1, 32'h00C, 32'h01020304, 4'h0, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[14] = mkv(1'b0, 32'h00C, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[15] = mkv(1'b0, 32'h1004, 32'h0,       4'h0, 3'b000, 1'b0, 32'hDEADBEEF, 3'b000);
    tbl[16] = mkv(1'b0, 32'h004, 32'h0,        4'h0, 3'b001, 1'b1, 32'h0, 3'b001);
    tbl[17] = mkv(1'b1, 32'h010, 32'h77777777, 4'hF, 3'b100, 1'b1, 32'h0, 3'b100);
    tbl[18] = mkv(1'b0, 32'h010, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0, 3'b000);
    tbl[19] = mkv(1'b0, 32'h010, 32'h0,        4'h0, 3'b110, 1'b0, 32'h0, 3'b000);

    for (int t = 0; t < 20; t++) begin
      xfer(0, tbl[t].w, tbl[t].a, tbl[t].d, tbl[t].st, tbl[t].fl, rd, er, rc, pe, waits);
      model_xfer(tbl[t].w, tbl[t].a, tbl[t].d, tbl[t].st, tbl[t].fl, ee, er32, ep);
      chk($sformatf("vec%0d_pslverr", t), {31'b0, er}, {31'b0, tbl[t].e});
      chk($sformatf("vec%0d_prdata", t), rd, tbl[t].r);
      chk($sformatf("vec%0d_par_err", t), {29'b0, pe}, {29'b0, tbl[t].p});
      chk($sformatf("vec%0d_waits", t), waits, 0);
    end
    chk("deadbeef_prdatachk", {28'b0, chk_a[0]}, 32'h0);
    xfer(0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b000, rd, er, rc, pe, waits);
    chk("deadbeef_rdchk", {28'b0, rc}, 32'h5);
    model_xfer(1'b0, 32'h004, 32'h0, 4'h0, 3'b000, ee, er32, ep);

    // access phase without setup: immediate error, no write
    sel = 0; psel = 1; penable = 1; pwrite = 1; paddr = 32'h004; pwdata = 32'h0;
    pstrb = 4'hF; paddrchk = bpar(32'h004); pwdatachk = bpar(32'h0); pstrbchk = 1'b0;
    @(negedge clk);
    chk("nosetup_pready", {31'b0, o_pready}, 32'h1);
    chk("nosetup_pslverr", {31'b0, o_pslverr}, 32'h1);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    xfer(0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b000, rd, er, rc, pe, waits);
    chk("nosetup_kept", rd, mem[1]);

    for (int n = 0; n < 200; n++) begin
      logic w;
      logic [31:0] a, d;
      logic [3:0] st;
      logic [2:0] fl;
      int r, wd;
      r  = $urandom_range(0, 9);
      wd = $urandom_range(0, 7);
      if (r < 7)       a = 32'(wd * 4);
      else if (r == 7) a = 32'($urandom_range(8, 15) * 4);
      else if (r == 8) a = 32'(wd * 4 + $urandom_range(1, 3));
      else             a = ($urandom & 32'hFFFFF000) | 32'(wd * 4);
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      st = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      model_xfer(w, a, d, st, fl, ee, er32, ep);
      xfer(0, w, a, d, st, fl, rd, er, rc, pe, waits);
      chk("rand_pslverr", {31'b0, er}, {31'b0, ee});
      chk("rand_prdata", rd, er32);
      chk("rand_prdatachk", {28'b0, rc}, {28'b0, bpar(er32)});
      chk("rand_par_err", {29'b0, pe}, {29'b0, ep});
    end
    for (int i = 0; i < 8; i++) chk($sformatf("regs_q%0d", i), rq[0][i*32 +: 32], mem[i]);

    // three wait states
    xfer(1, 1'b1, 32'h014, 32'h0BADF00D, 4'hF, 3'b000, rd, er, rc, pe, waits);
    chk("ws3_wr_waits", waits, 3);
    chk("ws3_wr_pslverr", {31'b0, er}, 32'h0);
    xfer(1, 1'b0, 32'h014, 32'h0, 4'h0, 3'b000, rd, er, rc, pe, waits);
    chk("ws3_rd_waits", waits, 3);
    chk("ws3_rd_cycles", waits + 2, 5);
    chk("ws3_rd_data", rd, 32'h0BADF00D);

    // PSEL dropped during ACCESS
    sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h018; pwdata = 32'h12345678;
    pstrb = 4'hF; paddrchk = bpar(32'h018); pwdatachk = bpar(32'h12345678); pstrbchk = 1'b0;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("drop_wait_pready", {31'b0, o_pready}, 32'h0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(negedge clk);
    chk("drop_pready", {31'b0, o_pready}, 32'h0);
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h018, 32'h0, 4'h0, 3'b000, rd, er, rc, pe, waits);
    chk("drop_no_write", rd, 32'h0);

    // reset during the access phase of a write
    sel = 2; psel = 1; penable = 0; pwrite = 1; paddr = 32'h010; pwdata = 32'hA5A5A5A5;
    pstrb = 4'hF; paddrchk = bpar(32'h010); pwdatachk = bpar(32'hA5A5A5A5); pstrbchk = 1'b0;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("rstmid_wait_pready", {31'b0, o_pready}, 32'h0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_pready", {31'b0, o_pready}, 32'h0);
    chk("rstmid_regs_q", {31'b0, |rq[2]}, 32'h0);
    psel = 0; penable = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h010, 32'h0, 4'h0, 3'b000, rd, er, rc, pe, waits);
    chk("rstmid_read", rd, 32'h0);
    chk("rstmid_waits", waits, 2);
    chk("rstmid_pslverr", {31'b0, er}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
